contador_canales: RTL

Parametrised multi-channel occupancy counter for the memory datapath. It keeps one up/down counter per channel, incremented by `push` and decremented by `pop`. Counters can saturate or wrap, and sticky overflow/underflow flags are kept per channel. Any counter can be read out through a req/valid handshake, with optional clear-on-read. It generalises the single 3-bit push counter to N channels, configurable width, a decrement path and a readout port. It sits beside the per-channel FIFOs, and the flow-control logic reads from it.

---
 rtl/contador_canales.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/contador_canales.sv
`default_nettype none
// ============================================================================
// Module      : contador_canales
// Description : Multi-channel occupancy counter. One up/down counter per
//               channel (push increments, pop decrements), saturating or
//               wrapping on increment, holding at zero on decrement, with
//               sticky per-channel overflow/underflow flags. Any counter can
//               be read through a req/valid handshake, with optional
//               clear-on-read.
// Ports       : clk, reset            clock, synchronous active-high reset
//               push, push_ch         increment request and channel
//               pop, pop_ch           decrement request and channel
//               req, req_ch           read request and channel (IDLE only)
//               cuenta, valid         registered readout value and strobe
//               busy                  read in progress, req ignored
//               overflow, underflow   sticky per-channel flags
// Revision    : 1.0 - initial release
// ============================================================================
module contador_canales #(
    parameter int WIDTH         = 3,
    parameter int CHANNELS      = 4,
    parameter int SATURATE      = 1,
    parameter int CLEAR_ON_READ = 0,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [CH_W-1:0]     push_ch,
    input  logic                pop,
    input  logic [CH_W-1:0]     pop_ch,
    input  logic                req,
    input  logic [CH_W-1:0]     req_ch,
    output logic [WIDTH-1:0]    cuenta,
    output logic                valid,
    output logic                busy,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] underflow
);

    localparam logic [0:0]       c_IDLE   = 1'b0;
    localparam logic [0:0]       c_READ   = 1'b1;
    localparam logic [WIDTH-1:0] c_MAX    = '1;
    localparam logic [CH_W:0]    c_NUM_CH = (CH_W + 1)'(CHANNELS);

    logic [0:0]       r_state;
    logic [CH_W-1:0]  r_sel_ch;
    logic [WIDTH-1:0] r_cuenta;
    logic             r_valid;
    logic             w_req_ok;
    logic [WIDTH-1:0] w_cnt [CHANNELS];

    // Extend by one bit so the range check also works when CHANNELS is a
    // power of two.
    assign w_req_ok = ({1'b0, req_ch} < c_NUM_CH);

    // ------------------------------------------------------------------------
    // Per-channel counter and sticky flags
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0] r_cnt;
        logic             r_ovf;
        logic             r_unf;
        logic             w_inc;
        logic             w_dec;
        logic             w_rd;

        assign w_inc = push && (push_ch == CH_W'(c));
        assign w_dec = pop  && (pop_ch  == CH_W'(c));
        // Readout edge for this channel
        assign w_rd  = (r_state == c_READ) && (r_sel_ch == CH_W'(c));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_rd) begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end
                if (w_rd && (CLEAR_ON_READ != 0)) begin
                    // Restart from zero plus this edge's net effect; a pop on
                    // an emptied counter is not an underflow.
                    r_cnt <= (w_inc && !w_dec) ? WIDTH'(1) : '0;
                end else if (w_inc && !w_dec) begin
                    if (r_cnt == c_MAX) begin
                        r_ovf <= 1'b1;
                        r_cnt <= (SATURATE != 0) ? c_MAX : '0;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end else if (w_dec && !w_inc) begin
                    if (r_cnt == '0) begin
                        r_unf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - WIDTH'(1);
                    end
                end
            end
        end

        assign w_cnt[c]     = r_cnt;
        assign overflow[c]  = r_ovf;
        assign underflow[c] = r_unf;
    end

    // ------------------------------------------------------------------------
    // Readout FSM: IDLE latches a legal request, READ produces the strobe
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_sel_ch <= '0;
            r_cuenta <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req && w_req_ok) begin
                        r_sel_ch <= req_ch;
                        r_state  <= c_READ;
                    end
                end
                c_READ: begin
                    // Counter value before this edge's push/pop
                    r_cuenta <= w_cnt[r_sel_ch];
                    r_valid  <= 1'b1;
                    r_state  <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cuenta = r_cuenta;
    assign valid  = r_valid;
    assign busy   = (r_state == c_READ);

endmodule
`default_nettype wire
